// File: rtl/gpio_in_debounce_if.sv
// Pin-conditioner bus: raw pins and parity controls in, GPIOIN word and change pulse out.
// The slave side is the debounce block; the master side is whatever drives and observes it.
interface gpio_in_debounce_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] PINS_IN;
  logic             PARITYSEL;
  logic             ERRINJ;
  logic [WIDTH:0]   GPIOIN;
  logic             CHANGED;

  modport master (
    output PINS_IN, PARITYSEL, ERRINJ,
    input  GPIOIN, CHANGED
  );

  modport slave (
    input  PINS_IN, PARITYSEL, ERRINJ,
    output GPIOIN, CHANGED
  );
endinterface

// File: rtl/gpio_in_debounce.sv
// Per-pin synchroniser plus counter debouncer feeding the AHB GPIO GPIOIN bus.
// A parity bit is appended over the debounced word, with an inversion input for fault injection.
module gpio_in_debounce #(
  parameter  int WIDTH           = 16,
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic             HCLK,
  input logic             HRESET,
  gpio_in_debounce_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] stable_r;
  logic [WIDTH-1:0] stable_nxt_s;
  logic [WIDTH-1:0] commit_s;
  logic [CNT_W-1:0] cnt_r     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
  logic             changed_r;
  logic [WIDTH-1:0] samp_s;

  function automatic logic parity_f(input logic [WIDTH-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

  assign samp_s = sync_r[SYNC_STAGES-1];

  // Plain flop chain per pin, nothing between stages
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= '0;
    end else begin
      sync_r[0] <= bus.PINS_IN;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];
    end
  end

  // Debounce next state: any sample matching the committed level discards progress
  always_comb begin
    stable_nxt_s = stable_r;
    commit_s     = '0;
    cnt_nxt_s    = '{default: '0};
    for (int i = 0; i < WIDTH; i++) begin
      if (samp_s[i] == stable_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] == CNT_MAX) begin
        stable_nxt_s[i] = samp_s[i];
        commit_s[i]     = 1'b1;
        cnt_nxt_s[i]    = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Debounce state and the one-cycle change pulse
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      stable_r  <= '0;
      changed_r <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_r[i] <= '0;
    end else begin
      stable_r  <= stable_nxt_s;
      changed_r <= |commit_s;
      for (int i = 0; i < WIDTH; i++) cnt_r[i] <= cnt_nxt_s[i];
    end
  end

  // Parity follows PARITYSEL/ERRINJ combinationally; the data path is fully registered
  assign bus.GPIOIN  = {parity_f(stable_r, bus.PARITYSEL) ^ bus.ERRINJ, stable_r};
  assign bus.CHANGED = changed_r;

endmodule
